// File: rtl/tmds_decoder_if.sv
// tmds_decoder_if -- connection between a 10-bit deserializer and the TMDS
// character decoder.
//   tmds_char : raw 10-bit character from the deserializer (bit 0 first on the wire)
//   bitslip   : one-cycle request to move the deserializer word boundary by one bit
//   locked    : decoder has found character alignment
//   de        : data/ctl/data outputs currently carry a video-data character
//   ctl       : {c1,c0} of the most recent control token
//   data      : decoded pixel byte
// master = deserializer side, slave = decoder side.
interface tmds_decoder_if;
    logic [9:0] tmds_char;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic [1:0] ctl;
    logic [7:0] data;

    modport master (
        output tmds_char,
        input  bitslip, locked, de, ctl, data
    );

    modport slave (
        input  tmds_char,
        output bitslip, locked, de, ctl, data
    );
endinterface

// File: rtl/tmds_decoder.sv
// tmds_decoder -- TMDS character decoder with word-alignment search.
// Ports:
//   pixel_clk : sole clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : tmds_decoder_if.slave (tmds_char in; bitslip, locked, de, ctl, data out)
// Pipeline: stage 1 registers the raw character, stage 2 registers the decoded
// outputs, so outputs follow tmds_char by exactly two cycles. The alignment FSM
// watches the stage-1 character: a run of LOCK_COUNT control tokens declares
// lock; SEARCH_LIMIT cycles without lock request a bitslip, after which
// SETTLE_CYCLES cycles are ignored while the deserializer realigns. In LOCKED,
// LOSS_LIMIT consecutive cycles without a token drop back to SEARCH.
module tmds_decoder #(
    parameter int LOCK_COUNT    = 16,
    parameter int SEARCH_LIMIT  = 2048,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOSS_LIMIT    = 4096
) (
    input  logic               pixel_clk,
    input  logic               rst,
    tmds_decoder_if.slave      bus
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int TMO_W  = $clog2(SEARCH_LIMIT + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int LOSS_W = $clog2(LOSS_LIMIT + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_COUNT);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(SEARCH_LIMIT);
    localparam logic [SET_W-1:0]  SET_MAX  = SET_W'(SETTLE_CYCLES);
    localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_LIMIT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Returns {is_token, c1, c0}; anything that is not one of the four
    // control tokens is reported as not-a-token.
    function automatic logic [2:0] tok_decode(input logic [9:0] c);
        logic [2:0] r;
        case (c)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    // Undo the TMDS transition-minimising stage: bit 9 flags an inverted
    // payload, bit 8 selects XOR (1) or XNOR (0) chaining.
    function automatic logic [7:0] data_decode(input logic [9:0] c);
        logic [7:0] q;
        logic [7:0] d;
        q = c[9] ? ~c[7:0] : c[7:0];
        d = {q[7:1] ^ q[6:0], q[0]};
        if (!c[8]) begin
            d[7:1] = ~d[7:1];
        end else begin
            d[7:1] = d[7:1];
        end
        return d;
    endfunction

    state_t              r_state;
    logic [9:0]          r_char;
    logic [RUN_W-1:0]    r_run;
    logic [TMO_W-1:0]    r_tmo;
    logic [SET_W-1:0]    r_settle;
    logic [LOSS_W-1:0]   r_loss;
    logic                r_bitslip;
    logic                r_locked;
    logic                r_de;
    logic [1:0]          r_ctl;
    logic [7:0]          r_data;

    state_t              w_state_nxt;
    logic [RUN_W-1:0]    w_run_nxt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic [SET_W-1:0]    w_settle_nxt;
    logic [LOSS_W-1:0]   w_loss_nxt;
    logic [RUN_W-1:0]    w_run_inc;
    logic [TMO_W-1:0]    w_tmo_inc;
    logic [SET_W-1:0]    w_settle_inc;
    logic [LOSS_W-1:0]   w_loss_inc;
    logic [2:0]          w_tok;
    logic                w_is_tok;
    logic [7:0]          w_dec;
    logic                w_de_nxt;
    logic [1:0]          w_ctl_nxt;
    logic [7:0]          w_data_nxt;

    assign w_tok    = tok_decode(r_char);
    assign w_is_tok = w_tok[2];
    assign w_dec    = data_decode(r_char);

    // Saturating increments: counters stick at their limit instead of wrapping.
    assign w_run_inc    = (r_run    == RUN_MAX)  ? RUN_MAX  : r_run    + RUN_W'(1);
    assign w_tmo_inc    = (r_tmo    == TMO_MAX)  ? TMO_MAX  : r_tmo    + TMO_W'(1);
    assign w_settle_inc = (r_settle == SET_MAX)  ? SET_MAX  : r_settle + SET_W'(1);
    assign w_loss_inc   = (r_loss   == LOSS_MAX) ? LOSS_MAX : r_loss   + LOSS_W'(1);

    // Alignment FSM next-state and counter update.
    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = r_run;
        w_tmo_nxt    = r_tmo;
        w_settle_nxt = r_settle;
        w_loss_nxt   = r_loss;
        case (r_state)
            ST_SEARCH: begin
                w_run_nxt = w_is_tok ? w_run_inc : RUN_W'(0);
                w_tmo_nxt = w_tmo_inc;
                // A completed token run wins over a simultaneous timeout.
                if (w_is_tok && (w_run_inc == RUN_MAX)) begin
                    w_state_nxt = ST_LOCKED;
                    w_run_nxt   = RUN_W'(0);
                    w_tmo_nxt   = TMO_W'(0);
                    w_loss_nxt  = LOSS_W'(0);
                end else if (w_tmo_inc == TMO_MAX) begin
                    w_state_nxt = ST_SLIP;
                    w_run_nxt   = RUN_W'(0);
                    w_tmo_nxt   = TMO_W'(0);
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_SLIP: begin
                w_state_nxt  = ST_SETTLE;
                w_settle_nxt = SET_W'(0);
            end
            ST_SETTLE: begin
                w_settle_nxt = w_settle_inc;
                if (w_settle_inc == SET_MAX) begin
                    // Fresh search: a run already in flight is not credited.
                    w_state_nxt  = ST_SEARCH;
                    w_settle_nxt = SET_W'(0);
                    w_run_nxt    = RUN_W'(0);
                    w_tmo_nxt    = TMO_W'(0);
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_LOCKED: begin
                w_loss_nxt = w_is_tok ? LOSS_W'(0) : w_loss_inc;
                if (!w_is_tok && (w_loss_inc == LOSS_MAX)) begin
                    w_state_nxt = ST_SEARCH;
                    w_loss_nxt  = LOSS_W'(0);
                    w_run_nxt   = RUN_W'(0);
                    w_tmo_nxt   = TMO_W'(0);
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt  = ST_SEARCH;
                w_run_nxt    = RUN_W'(0);
                w_tmo_nxt    = TMO_W'(0);
                w_settle_nxt = SET_W'(0);
                w_loss_nxt   = LOSS_W'(0);
            end
        endcase
    end

    // Stage-2 output selection, qualified by the state the character was seen in.
    always_comb begin
        w_de_nxt   = 1'b0;
        w_ctl_nxt  = 2'b00;
        w_data_nxt = 8'h00;
        if (r_state == ST_LOCKED) begin
            if (w_is_tok) begin
                w_ctl_nxt = w_tok[1:0];
            end else begin
                w_de_nxt   = 1'b1;
                w_ctl_nxt  = r_ctl;
                w_data_nxt = w_dec;
            end
        end else begin
            w_ctl_nxt = 2'b00;
        end
    end

    // Pipeline, FSM and counter registers; reset overrides every transition.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state   <= ST_SEARCH;
            r_char    <= 10'd0;
            r_run     <= RUN_W'(0);
            r_tmo     <= TMO_W'(0);
            r_settle  <= SET_W'(0);
            r_loss    <= LOSS_W'(0);
            r_bitslip <= 1'b0;
            r_locked  <= 1'b0;
            r_de      <= 1'b0;
            r_ctl     <= 2'b00;
            r_data    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_char    <= bus.tmds_char;
            r_run     <= w_run_nxt;
            r_tmo     <= w_tmo_nxt;
            r_settle  <= w_settle_nxt;
            r_loss    <= w_loss_nxt;
            // SLIP always exits after one cycle, so this is a single pulse.
            r_bitslip <= (w_state_nxt == ST_SLIP);
            r_locked  <= (w_state_nxt == ST_LOCKED);
            r_de      <= w_de_nxt;
            r_ctl     <= w_ctl_nxt;
            r_data    <= w_data_nxt;
        end
    end

    assign bus.bitslip = r_bitslip;
    assign bus.locked  = r_locked;
    assign bus.de      = r_de;
    assign bus.ctl     = r_ctl;
    assign bus.data    = r_data;

endmodule
